// File: rtl/param_fifo_pkg.sv
// Shared definitions for param_fifo: the clog2 helper, the depth derivation
// and the legality checks on the depth and threshold parameters.
package param_fifo_pkg;

  localparam int unsigned MinAddrBit = 1;
  localparam int unsigned MaxAddrBit = 12;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned addr_bit);
    return 32'd1 << addr_bit;
  endfunction

  function automatic bit addr_bit_ok(input int unsigned addr_bit);
    return (addr_bit >= MinAddrBit) && (addr_bit <= MaxAddrBit);
  endfunction

  function automatic bit af_level_ok(input int unsigned lvl, input int unsigned depth);
    return (lvl >= 1) && (lvl <= depth);
  endfunction

  function automatic bit ae_level_ok(input int unsigned lvl, input int unsigned depth);
    return lvl < depth;
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Stream-side bundle of param_fifo.
//   master: producer/consumer side, drives wen/in/ren, observes data and status.
//   slave : the FIFO itself.
interface param_fifo_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_BIT = 3
);
  logic                wen;
  logic [WIDTH-1:0]    in;
  logic                ren;
  logic [WIDTH-1:0]    out;
  logic                valid;
  logic                empty;
  logic                full;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDR_BIT:0]   cnt;
  logic                overflow;
  logic                underflow;

  modport master (
    output wen, in, ren,
    input  out, valid, empty, full, almost_full, almost_empty, cnt, overflow, underflow
  );

  modport slave (
    input  wen, in, ren,
    output out, valid, empty, full, almost_full, almost_empty, cnt, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM for param_fifo, WIDTH x DEPTH, storage not reset.
//   clk_i/rst_i    : clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_i        : read address shared by both read ports
//   rdata_async_o  : combinational read of mem[raddr_i]
//   re_i/rdata_reg_o : registered read, loads mem[raddr_i] when re_i
module fifo_mem
  import param_fifo_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_async_o,
  output logic [WIDTH-1:0] rdata_reg_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Sampling mem_q on the same edge as a write to the same slot returns the
  // old word, which is what a read at full occupancy needs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_async_o = mem_q[raddr_i];
  assign rdata_reg_o   = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with optional first-word-fall-through output,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : param_fifo_if.slave (wen/in/ren in; out/valid/status/cnt out)
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_BIT = 3,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = fifo_depth(ADDR_BIT) - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic          clk,
  input logic          rst,
  param_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_BIT);

  if (!addr_bit_ok(ADDR_BIT)) begin : g_bad_addr_bit
    $error("param_fifo: ADDR_BIT out of range 1..12");
  end
  if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_af_level
    $error("param_fifo: AF_LEVEL out of range 1..DEPTH");
  end
  if (!ae_level_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae_level
    $error("param_fifo: AE_LEVEL out of range 0..DEPTH-1");
  end

  localparam logic [ADDR_BIT:0]   CntFull = (ADDR_BIT+1)'(DEPTH);
  localparam logic [ADDR_BIT:0]   CntAf   = (ADDR_BIT+1)'(AF_LEVEL);
  localparam logic [ADDR_BIT:0]   CntAe   = (ADDR_BIT+1)'(AE_LEVEL);
  localparam logic [ADDR_BIT:0]   CntOne  = (ADDR_BIT+1)'(1);
  localparam logic [ADDR_BIT-1:0] PtrOne  = ADDR_BIT'(1);

  logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BIT:0]   cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic             empty, full;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] rdata_async, rdata_reg;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntFull);

  // A read frees a slot in the same cycle, so a write at full still lands.
  assign rd_ok = bus.ren && !empty;
  assign wr_ok = bus.wen && (!full || rd_ok);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i         (clk),
    .rst_i         (rst),
    .we_i          (wr_ok),
    .waddr_i       (wr_ptr_q),
    .wdata_i       (bus.in),
    .re_i          (rd_ok),
    .raddr_i       (rd_ptr_q),
    .rdata_async_o (rdata_async),
    .rdata_reg_o   (rdata_reg)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    valid_d     = rd_ok;
    overflow_d  = overflow_q  | (bus.wen && !wr_ok);
    underflow_d = underflow_q | (bus.ren && empty);
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PtrOne;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    bus.empty        = empty;
    bus.full         = full;
    bus.almost_full  = (cnt_q >= CntAf);
    bus.almost_empty = (cnt_q <= CntAe);
    bus.cnt          = cnt_q;
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
    if (FWFT != 0) begin
      // Head word shown straight from storage; zero when nothing is queued.
      bus.valid = !empty;
      bus.out   = empty ? '0 : rdata_async;
    end else begin
      bus.valid = valid_q;
      bus.out   = rdata_reg;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: three instances (registered read, FWFT, and
// registered read with AF_LEVEL=6/AE_LEVEL=2 for the interleaved run).
module tb_param_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_fifo_if #(.WIDTH(8), .ADDR_BIT(3)) a_if ();
  param_fifo_if #(.WIDTH(8), .ADDR_BIT(3)) b_if ();
  param_fifo_if #(.WIDTH(8), .ADDR_BIT(3)) c_if ();

  param_fifo #(.WIDTH(8), .ADDR_BIT(3), .FWFT(0)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  param_fifo #(.WIDTH(8), .ADDR_BIT(3), .FWFT(1)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  param_fifo #(.WIDTH(8), .ADDR_BIT(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_c (
    .clk(clk), .rst(rst), .bus(c_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_if.wen = 1'b0; a_if.ren = 1'b0; a_if.in = 8'h00;
    b_if.wen = 1'b0; b_if.ren = 1'b0; b_if.in = 8'h00;
    c_if.wen = 1'b0; c_if.ren = 1'b0; c_if.in = 8'h00;
  endtask

  logic [7:0] exp_rd [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};

  logic [7:0] q[$];
  logic [7:0] exp_out;
  logic       exp_valid, ovf_m, udf_m;

  initial begin
    idle_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check_eq("rst_cnt",   a_if.cnt, 0);
    check_eq("rst_empty", a_if.empty, 1);
    check_eq("rst_full",  a_if.full, 0);
    check_eq("rst_ae",    a_if.almost_empty, 1);
    check_eq("rst_af",    a_if.almost_full, 0);
    check_eq("rst_valid", a_if.valid, 0);
    check_eq("rst_out",   a_if.out, 0);
    check_eq("rst_ovf",   a_if.overflow, 0);
    check_eq("rst_udf",   a_if.underflow, 0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      a_if.wen = 1'b1;
      a_if.in  = 8'(i);
      step();
      check_eq("fill_cnt",  a_if.cnt, i);
      check_eq("fill_af",   a_if.almost_full, (i >= 7));
      check_eq("fill_ae",   a_if.almost_empty, (i <= 1));
      check_eq("fill_full", a_if.full, (i == 8));
    end
    // 9th write is dropped
    a_if.in = 8'h99;
    step();
    check_eq("ovf_cnt",  a_if.cnt, 8);
    check_eq("ovf_flag", a_if.overflow, 1);
    check_eq("ovf_full", a_if.full, 1);

    // Full with ren and wen: oldest word out, 0xAA fills the freed slot
    a_if.ren = 1'b1;
    a_if.in  = 8'hAA;
    step();
    a_if.wen = 1'b0;
    check_eq("fullrw_out",   a_if.out, 8'h01);
    check_eq("fullrw_valid", a_if.valid, 1);
    check_eq("fullrw_cnt",   a_if.cnt, 8);
    check_eq("fullrw_ovf",   a_if.overflow, 1);

    // Drain: 0x02..0x08 then 0xAA
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("drain_out",   a_if.out, exp_rd[k]);
      check_eq("drain_valid", a_if.valid, 1);
      check_eq("drain_cnt",   a_if.cnt, 7 - k);
    end
    a_if.ren = 1'b0;
    step();
    check_eq("drained_valid", a_if.valid, 0);
    check_eq("drained_empty", a_if.empty, 1);
    check_eq("drained_hold",  a_if.out, 8'hAA);
    check_eq("drained_udf",   a_if.underflow, 0);

    // Empty with ren and wen: write lands, read rejected
    a_if.wen = 1'b1;
    a_if.ren = 1'b1;
    a_if.in  = 8'h55;
    step();
    a_if.wen = 1'b0;
    a_if.ren = 1'b0;
    check_eq("emptyrw_udf",   a_if.underflow, 1);
    check_eq("emptyrw_valid", a_if.valid, 0);
    check_eq("emptyrw_cnt",   a_if.cnt, 1);
    a_if.ren = 1'b1;
    step();
    a_if.ren = 1'b0;
    check_eq("emptyrw_rd_out",   a_if.out, 8'h55);
    check_eq("emptyrw_rd_valid", a_if.valid, 1);
    check_eq("emptyrw_rd_cnt",   a_if.cnt, 0);
    step();
    check_eq("emptyrw_udf_sticky", a_if.underflow, 1);

    // Mid-stream reset at cnt=5 with a concurrent write
    for (int i = 0; i < 5; i++) begin
      a_if.wen = 1'b1;
      a_if.in  = 8'(8'h20 + i);
      step();
    end
    check_eq("mrst_pre_cnt", a_if.cnt, 5);
    rst = 1'b1;
    a_if.in = 8'h77;
    step();
    rst = 1'b0;
    a_if.wen = 1'b0;
    check_eq("mrst_cnt",   a_if.cnt, 0);
    check_eq("mrst_empty", a_if.empty, 1);
    check_eq("mrst_valid", a_if.valid, 0);
    check_eq("mrst_ovf",   a_if.overflow, 0);
    check_eq("mrst_udf",   a_if.underflow, 0);
    a_if.wen = 1'b1;
    a_if.in  = 8'h66;
    step();
    a_if.wen = 1'b0;
    a_if.ren = 1'b1;
    step();
    a_if.ren = 1'b0;
    check_eq("mrst_rd_out",   a_if.out, 8'h66);
    check_eq("mrst_rd_valid", a_if.valid, 1);
    check_eq("mrst_rd_empty", a_if.empty, 1);

    // FWFT instance
    check_eq("fwft_idle_valid", b_if.valid, 0);
    check_eq("fwft_idle_out",   b_if.out, 0);
    b_if.wen = 1'b1;
    b_if.in  = 8'h10;
    step();
    b_if.wen = 1'b0;
    check_eq("fwft_first_valid", b_if.valid, 1);
    check_eq("fwft_first_out",   b_if.out, 8'h10);
    b_if.wen = 1'b1;
    b_if.in  = 8'h11;
    step();
    b_if.in  = 8'h12;
    step();
    b_if.wen = 1'b0;
    check_eq("fwft_cnt3",  b_if.cnt, 3);
    check_eq("fwft_head",  b_if.out, 8'h10);
    b_if.ren = 1'b1;
    step();
    b_if.ren = 1'b0;
    check_eq("fwft_pop1_out", b_if.out, 8'h11);
    b_if.ren = 1'b1;
    step();
    b_if.ren = 1'b0;
    check_eq("fwft_pop2_out",   b_if.out, 8'h12);
    check_eq("fwft_pop2_valid", b_if.valid, 1);
    b_if.ren = 1'b1;
    step();
    b_if.ren = 1'b0;
    check_eq("fwft_pop3_valid", b_if.valid, 0);
    check_eq("fwft_pop3_out",   b_if.out, 0);
    check_eq("fwft_pop3_empty", b_if.empty, 1);

    // Interleaved run on the AF=6/AE=2 instance against a queue model
    exp_out   = 8'h00;
    exp_valid = 1'b0;
    ovf_m     = 1'b0;
    udf_m     = 1'b0;
    for (int n = 0; n < 48; n++) begin
      logic       w, r, rd_ok_m, wr_ok_m;
      logic [7:0] d;
      int         sz;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      sz = q.size();
      rd_ok_m = r && (sz > 0);
      wr_ok_m = w && ((sz < 8) || rd_ok_m);
      ovf_m   = ovf_m | (w && !wr_ok_m);
      udf_m   = udf_m | (r && (sz == 0));
      c_if.wen = w;
      c_if.ren = r;
      c_if.in  = d;
      step();
      exp_valid = rd_ok_m;
      if (rd_ok_m) exp_out = q.pop_front();
      if (wr_ok_m) q.push_back(d);
      check_eq("rnd_cnt",   c_if.cnt, q.size());
      check_eq("rnd_valid", c_if.valid, exp_valid);
      check_eq("rnd_out",   c_if.out, exp_out);
      check_eq("rnd_af",    c_if.almost_full, (q.size() >= 6));
      check_eq("rnd_ae",    c_if.almost_empty, (q.size() <= 2));
      check_eq("rnd_ovf",   c_if.overflow, ovf_m);
      check_eq("rnd_udf",   c_if.underflow, udf_m);
    end
    idle_all();
    step();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
